// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   DEFAULT_RESET_PC  : fetch address after reset
//   DEFAULT_NOP_INSTR : bubble encoding (addi x0,x0,0)
//   fetch_state_e     : fetch controller states
//   word_align()      : clears the byte-offset bits of an address
package fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH,
        BUFFERED,
        DROP
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetched {pc, instr} pair while the
// decode stage is stalled.
//   clk, rst : clock and synchronous active-high reset
//   load     : capture wr_data, mark full
//   unload   : mark empty (entry consumed)
//   clear    : mark empty (entry squashed), wins over load
//   wr_data  : {pc[31:0], instr[31:0]}
//   rd_data  : stored entry
//   full     : entry is valid
module fetch_skid (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        unload,
    input  logic        clear,
    input  logic [63:0] wr_data,
    output logic [63:0] rd_data,
    output logic        full
);

    logic [63:0] data_q;
    logic        full_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else if (load) begin
            data_q <= wr_data;
            full_q <= 1'b1;
        end else if (unload) begin
            full_q <= 1'b0;
        end
    end

    assign rd_data = data_q;
    assign full    = full_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID pipeline register.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   Stall_i                : hold IF/ID
//   PCWrite_i              : allow a new fetch to start
//   Flush_i, BranchAddr_i  : squash IF/ID and redirect the fetch pointer
//   imem_req_o/addr_o      : instruction memory request (one outstanding)
//   imem_ack_i/data_i      : instruction memory response
//   IFID_pc_o/instr_o/valid_o : IF/ID register contents
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        Stall_i,
    input  logic        PCWrite_i,
    input  logic        Flush_i,
    input  logic [31:0] BranchAddr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] IFID_pc_o,
    output logic [31:0] IFID_instr_o,
    output logic        IFID_valid_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  drop_addr_q, drop_addr_d;
    logic         req_q, req_d;
    logic [31:0]  ifid_pc_q, ifid_pc_d;
    logic [31:0]  ifid_instr_q, ifid_instr_d;
    logic         ifid_valid_q, ifid_valid_d;

    logic         ack;
    logic         skid_load, skid_unload, skid_clear, skid_full;
    logic [63:0]  skid_rd_data;

    // Acks are only meaningful while a request is on the bus.
    assign ack = imem_ack_i & req_q;

    fetch_skid u_skid (
        .clk     (clk_i),
        .rst     (rst_i),
        .load    (skid_load),
        .unload  (skid_unload),
        .clear   (skid_clear),
        .wr_data ({pc_q, imem_data_i}),
        .rd_data (skid_rd_data),
        .full    (skid_full)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_addr_d  = drop_addr_q;
        req_d        = req_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        skid_load    = 1'b0;
        skid_unload  = 1'b0;
        skid_clear   = 1'b0;

        if (Flush_i) begin
            pc_d         = word_align(BranchAddr_i);
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            skid_clear   = 1'b0 | 1'b1;
            if (req_q && !ack) begin
                // Keep the bus request stable and swallow its response later.
                state_d = DROP;
                req_d   = 1'b1;
                if (state_q != DROP) begin
                    drop_addr_d = pc_q;
                end
            end else begin
                state_d = FETCH;
                req_d   = PCWrite_i;
            end
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (ack) begin
                        pc_d = pc_q + 32'd4;
                        if (Stall_i) begin
                            skid_load = 1'b1;
                            state_d   = BUFFERED;
                            req_d     = 1'b0;
                        end else begin
                            ifid_pc_d    = pc_q;
                            ifid_instr_d = imem_data_i;
                            ifid_valid_d = 1'b1;
                            req_d        = PCWrite_i;
                        end
                    end else begin
                        if (!Stall_i) begin
                            ifid_instr_d = NOP_INSTR;
                            ifid_valid_d = 1'b0;
                        end
                        req_d = req_q | PCWrite_i;
                    end
                end
                BUFFERED: begin
                    if (!Stall_i) begin
                        ifid_pc_d    = skid_rd_data[63:32];
                        ifid_instr_d = skid_full ? skid_rd_data[31:0] : NOP_INSTR;
                        ifid_valid_d = skid_full;
                        skid_unload  = 1'b1;
                        state_d      = FETCH;
                        req_d        = PCWrite_i;
                    end
                end
                DROP: begin
                    if (!Stall_i) begin
                        ifid_instr_d = NOP_INSTR;
                        ifid_valid_d = 1'b0;
                    end
                    if (ack) begin
                        state_d = FETCH;
                        req_d   = PCWrite_i;
                    end
                end
                default: begin
                    state_d = FETCH;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            drop_addr_q  <= '0;
            req_q        <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_addr_q  <= drop_addr_d;
            req_q        <= req_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign imem_req_o   = req_q;
    // While dropping, pc_q already holds the redirect target.
    assign imem_addr_o  = (state_q == DROP) ? drop_addr_q : pc_q;
    assign IFID_pc_o    = ifid_pc_q;
    assign IFID_instr_o = ifid_instr_q;
    assign IFID_valid_o = ifid_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable memory responder
// and a scoreboard of expected IF/ID instructions.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        Stall_i = 1'b0;
    logic        PCWrite_i = 1'b1;
    logic        Flush_i = 1'b0;
    logic [31:0] BranchAddr_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = '0;
    logic [31:0] IFID_pc_o;
    logic [31:0] IFID_instr_o;
    logic        IFID_valid_o;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   mem_lat = 1;
    bit   force_ack = 1'b0;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .Stall_i      (Stall_i),
        .PCWrite_i    (PCWrite_i),
        .Flush_i      (Flush_i),
        .BranchAddr_i (BranchAddr_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_data_i  (imem_data_i),
        .IFID_pc_o    (IFID_pc_o),
        .IFID_instr_o (IFID_instr_o),
        .IFID_valid_o (IFID_valid_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] addr);
        return (addr * 32'h0001_0001) + 32'h1234_5670;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = instr_of(pc);
        sb.push_back(e);
    endtask

    // Advance one cycle; a freshly loaded valid IF/ID entry is checked
    // against the scoreboard (a stalled edge only holds the old entry).
    task automatic tick();
        logic stalled;
        exp_t e;
        stalled = Stall_i;
        @(negedge clk);
        if (IFID_valid_o && !stalled) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_instr", IFID_pc_o, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("sb_pc", IFID_pc_o, e.pc);
                check("sb_instr", IFID_instr_o, e.instr);
            end
        end
    endtask

    // Memory responder: acks on the mem_lat-th cycle of each request.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            #1;
            if (force_ack) begin
                imem_ack_i  = 1'b1;
                imem_data_i = 32'hDEAD_BEEF;
                wait_cnt    = 0;
            end else if (imem_req_o) begin
                if (wait_cnt + 1 >= mem_lat) begin
                    imem_ack_i  = 1'b1;
                    imem_data_i = instr_of(imem_addr_o);
                    wait_cnt    = 0;
                end else begin
                    imem_ack_i = 1'b0;
                    wait_cnt++;
                end
            end else begin
                imem_ack_i = 1'b0;
                wait_cnt   = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_req", {31'b0, imem_req_o}, 32'd0);
        check("rst_valid", {31'b0, IFID_valid_o}, 32'd0);
        check("rst_instr", IFID_instr_o, NOP);
        check("rst_pc", IFID_pc_o, 32'h0);
        check("rst_addr", imem_addr_o, 32'h0);

        // Zero-wait streaming: one instruction per cycle
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
        tick();
        check("first_req", {31'b0, imem_req_o}, 32'd1);
        check("first_addr", imem_addr_o, 32'h0);
        check("first_valid", {31'b0, IFID_valid_o}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stream_valid", {31'b0, IFID_valid_o}, 32'd1);
        end

        // Stall over the ack of 0x10 for two cycles
        Stall_i = 1'b1;
        push_exp(32'h10);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_hold_pc", IFID_pc_o, 32'hC);
            check("stall_hold_valid", {31'b0, IFID_valid_o}, 32'd1);
            check("buffered_no_req", {31'b0, imem_req_o}, 32'd0);
        end
        Stall_i = 1'b0;
        mem_lat = 3;
        tick();
        check("unbuffer_pc", IFID_pc_o, 32'h10);
        check("unbuffer_valid", {31'b0, IFID_valid_o}, 32'd1);
        check("after_unbuffer_addr", imem_addr_o, 32'h14);

        // Three-cycle memory latency
        for (int k = 0; k < 3; k++) begin
            logic [31:0] a;
            a = 32'h14 + 32'(k * 4);
            push_exp(a);
            for (int j = 0; j < 2; j++) begin
                tick();
                check("lat_bubble_valid", {31'b0, IFID_valid_o}, 32'd0);
                check("lat_bubble_instr", IFID_instr_o, NOP);
                check("lat_addr_stable", imem_addr_o, a);
            end
            tick();
            check("lat_valid", {31'b0, IFID_valid_o}, 32'd1);
            check("lat_next_addr", imem_addr_o, a + 32'd4);
        end

        // Flush while 0x20 is outstanding; low address bits ignored
        Flush_i = 1'b1;
        BranchAddr_i = 32'h0000_0103;
        push_exp(32'h100);
        tick();
        Flush_i = 1'b0;
        check("drop_req", {31'b0, imem_req_o}, 32'd1);
        check("drop_addr", imem_addr_o, 32'h20);
        check("drop_valid", {31'b0, IFID_valid_o}, 32'd0);
        tick();
        check("drop_addr2", imem_addr_o, 32'h20);
        check("drop_valid2", {31'b0, IFID_valid_o}, 32'd0);
        tick();
        check("redirect_valid", {31'b0, IFID_valid_o}, 32'd0);
        check("redirect_addr", imem_addr_o, 32'h100);
        for (int j = 0; j < 2; j++) begin
            tick();
            check("redirect_bubble", {31'b0, IFID_valid_o}, 32'd0);
        end
        tick();
        check("redirect_loaded", {31'b0, IFID_valid_o}, 32'd1);

        // Flush and stall together with the skid full
        mem_lat = 1;
        Stall_i = 1'b1;
        tick();
        check("skid_hold_pc", IFID_pc_o, 32'h100);
        check("skid_no_req", {31'b0, imem_req_o}, 32'd0);
        Flush_i = 1'b1;
        BranchAddr_i = 32'h40;
        tick();
        Flush_i = 1'b0;
        Stall_i = 1'b0;
        check("fs_valid", {31'b0, IFID_valid_o}, 32'd0);
        check("fs_instr", IFID_instr_o, NOP);
        check("fs_pc_kept", IFID_pc_o, 32'h100);
        check("fs_req", {31'b0, imem_req_o}, 32'd1);
        check("fs_addr", imem_addr_o, 32'h40);
        push_exp(32'h40);
        tick();
        check("fs_loaded", {31'b0, IFID_valid_o}, 32'd1);

        // Second flush while already dropping replaces the target
        mem_lat = 3;
        Flush_i = 1'b1;
        BranchAddr_i = 32'h80;
        tick();
        check("reflush_addr", imem_addr_o, 32'h44);
        BranchAddr_i = 32'h300;
        tick();
        Flush_i = 1'b0;
        check("reflush_req", {31'b0, imem_req_o}, 32'd1);
        check("reflush_addr2", imem_addr_o, 32'h44);
        push_exp(32'h300);
        tick();
        check("reflush_target", imem_addr_o, 32'h300);
        check("reflush_valid", {31'b0, IFID_valid_o}, 32'd0);
        tick();
        tick();
        tick();
        check("reflush_loaded", {31'b0, IFID_valid_o}, 32'd1);

        // Reset mid-request, late ack afterwards
        rst_i = 1'b1;
        tick();
        check("mid_rst_req", {31'b0, imem_req_o}, 32'd0);
        check("mid_rst_valid", {31'b0, IFID_valid_o}, 32'd0);
        check("mid_rst_pc", IFID_pc_o, 32'h0);
        check("mid_rst_addr", imem_addr_o, 32'h0);
        rst_i = 1'b0;
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        check("late_ack_ignored", {31'b0, IFID_valid_o}, 32'd0);
        check("post_rst_req", {31'b0, imem_req_o}, 32'd1);
        check("post_rst_addr", imem_addr_o, 32'h0);
        push_exp(32'h0);
        tick();
        tick();
        tick();
        check("post_rst_loaded", {31'b0, IFID_valid_o}, 32'd1);

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
